// File: rtl/axil_wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone classic bridge.
package axil_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_WR,
    ST_WB_RD,
    ST_B_RESP,
    ST_R_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_wb_hold_slot.sv
// One-entry valid/ready capture register; stays full until its Wishbone cycle
// retires it through i_clr. Ready is registered and therefore 0 during reset.
module axil_wb_hold_slot
  import axil_wb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_clr,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic         r_ready;
  logic [W-1:0] r_data;
  logic         w_hs;
  logic         w_full_nxt;

  assign w_hs       = i_valid && r_ready;
  assign w_full_nxt = i_clr ? 1'b0 : (w_hs ? 1'b1 : r_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= !w_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_data <= i_data;
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/axil_to_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master, one Wishbone cycle at a time,
// round-robin read/write arbitration. Optional ack timeout: AXIL_WB_TIMEOUT_EN.
module axil_to_wb_bridge
  import axil_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i
);

  localparam int SEL_W = DATA_WIDTH / 8;

  state_t                r_state, w_state_nxt;
  logic                  r_rr_last_rd;
  logic                  w_aw_full, w_w_full, w_ar_full;
  logic [ADDR_WIDTH-1:0] w_aw_addr, w_ar_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [SEL_W-1:0]      w_wstrb;
  logic                  w_wr_pend, w_rd_pend;
  logic                  w_grant_wr, w_grant_rd;
  logic                  w_clr_wr, w_clr_rd;
  logic                  w_abort;
  logic                  w_unused;

  assign w_unused = ^{awprot, arprot};

  axil_wb_hold_slot #(.W(ADDR_WIDTH)) u_aw_slot (
    .clk(clk), .rst_n(rst_n), .i_valid(awvalid), .o_ready(awready),
    .i_data(awaddr), .i_clr(w_clr_wr), .o_full(w_aw_full), .o_data(w_aw_addr)
  );

  axil_wb_hold_slot #(.W(DATA_WIDTH + SEL_W)) u_w_slot (
    .clk(clk), .rst_n(rst_n), .i_valid(wvalid), .o_ready(wready),
    .i_data({wdata, wstrb}), .i_clr(w_clr_wr), .o_full(w_w_full),
    .o_data({w_wdata, w_wstrb})
  );

  axil_wb_hold_slot #(.W(ADDR_WIDTH)) u_ar_slot (
    .clk(clk), .rst_n(rst_n), .i_valid(arvalid), .o_ready(arready),
    .i_data(araddr), .i_clr(w_clr_rd), .o_full(w_ar_full), .o_data(w_ar_addr)
  );

`ifdef AXIL_WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_tmo_cnt <= '0;
    else if (r_state == ST_WB_WR || r_state == ST_WB_RD) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    else                                                 r_tmo_cnt <= '0;
  end

  // An ack in the final cycle still wins over the abort.
  assign w_abort = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !wb_ack_i;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_abort      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    w_clr_wr    = 1'b0;
    w_clr_rd    = 1'b0;
    w_wr_pend   = w_aw_full && w_w_full;
    w_rd_pend   = w_ar_full;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_pend && (!w_rd_pend || r_rr_last_rd)) begin
          w_grant_wr  = 1'b1;
          w_state_nxt = ST_WB_WR;
        end else if (w_rd_pend) begin
          w_grant_rd  = 1'b1;
          w_state_nxt = ST_WB_RD;
        end
      end
      ST_WB_WR: if (wb_ack_i || w_abort) begin
        w_clr_wr    = 1'b1;
        w_state_nxt = ST_B_RESP;
      end
      ST_WB_RD: if (wb_ack_i || w_abort) begin
        w_clr_rd    = 1'b1;
        w_state_nxt = ST_R_RESP;
      end
      ST_B_RESP: if (bready) w_state_nxt = ST_IDLE;
      ST_R_RESP: if (rready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last_rd <= 1'b1;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      wb_sel_o     <= '0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
      rvalid       <= 1'b0;
      rdata        <= '0;
      rresp        <= RESP_OKAY;
    end else begin
      if (w_grant_wr) begin
        r_rr_last_rd <= 1'b0;
        wb_cyc_o     <= 1'b1;
        wb_stb_o     <= 1'b1;
        wb_we_o      <= 1'b1;
        wb_addr_o    <= w_aw_addr;
        wb_data_o    <= w_wdata;
        wb_sel_o     <= w_wstrb;
      end
      // Reads fetch the whole word; AXI-Lite has no read strobes.
      if (w_grant_rd) begin
        r_rr_last_rd <= 1'b1;
        wb_cyc_o     <= 1'b1;
        wb_stb_o     <= 1'b1;
        wb_we_o      <= 1'b0;
        wb_addr_o    <= w_ar_addr;
        wb_sel_o     <= '1;
      end
      if (w_clr_wr || w_clr_rd) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
      end
      if (w_clr_wr) begin
        bvalid <= 1'b1;
        bresp  <= wb_ack_i ? RESP_OKAY : RESP_SLVERR;
      end
      if (w_clr_rd) begin
        rvalid <= 1'b1;
        rdata  <= wb_ack_i ? wb_data_i : '0;
        rresp  <= wb_ack_i ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_state == ST_B_RESP && bready) bvalid <= 1'b0;
      if (r_state == ST_R_RESP && rready) rvalid <= 1'b0;
    end
  end

endmodule
